// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
//
// Purpose: access size encodings, sequencer state enum, requester ids and
//          the alignment legality check shared by the arbiter and its
//          lane-alignment helper.
// Ports:   none (package).
package mem_port_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  // Size 11 is never legal; half/word must sit on their natural boundary.
  function automatic logic access_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/response and memory bus bundle for the arbiter
//
// Purpose: groups the fetch-path, data-path and memory-side signals.
// Modports:
//   slave  - arbiter view: takes requests and MOC/mem_rdata, drives
//            done/err/rdata and the memory strobe/RW/address/size/wdata.
//   master - requester + memory view: the mirror image.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch path
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic              if_err;
  logic [DATA_W-1:0] if_rdata;
  // data path
  logic              dp_req;
  logic              dp_rw;
  logic [1:0]        dp_size;
  logic              dp_unsigned;
  logic [ADDR_W-1:0] dp_addr;
  logic [DATA_W-1:0] dp_wdata;
  logic              dp_done;
  logic              dp_err;
  logic [DATA_W-1:0] dp_rdata;
  // memory side
  logic              memEnable;
  logic              RW;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_size;
  logic [DATA_W-1:0] mem_wdata;
  logic              MOC;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dp_req, dp_rw, dp_size, dp_unsigned, dp_addr, dp_wdata,
           MOC, mem_rdata,
    output if_done, if_err, if_rdata, dp_done, dp_err, dp_rdata,
           memEnable, RW, mem_addr, mem_size, mem_wdata
  );

  modport master (
    output if_req, if_addr, dp_req, dp_rw, dp_size, dp_unsigned, dp_addr, dp_wdata,
           MOC, mem_rdata,
    input  if_done, if_err, if_rdata, dp_done, dp_err, dp_rdata,
           memEnable, RW, mem_addr, mem_size, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_load_align.sv
// rtl/mem_port_arbiter_load_align.sv - big-endian lane select, load extension, store replication
//
// Purpose: combinational helper; also used by the datapath MDR path.
// Ports:
//   size_i    access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   uns_i     1 zero-extend loads, 0 sign-extend
//   addr_lo_i address bits [1:0] selecting the lane
//   rdata_i   raw memory word
//   wdata_i   store data, low-order bits significant
//   ld_data_o selected lane shifted to LSBs and extended
//   st_data_o store data replicated into every lane of its size
module mem_port_arbiter_load_align (
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_data_o
);
  import mem_port_arbiter_pkg::*;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Big-endian: lane 00 is the most significant byte.
    case (addr_lo_i)
      2'b00:   byte_sel = rdata_i[31:24];
      2'b01:   byte_sel = rdata_i[23:16];
      2'b10:   byte_sel = rdata_i[15:8];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    case (size_i)
      SZ_BYTE: begin
        ld_data_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
        st_data_o = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        ld_data_o = {{16{~uns_i & half_sel[15]}}, half_sel};
        st_data_o = {2{wdata_i[15:0]}};
      end
      default: begin
        ld_data_o = rdata_i;
        st_data_o = wdata_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter and sequencer for the shared memory port
//
// Purpose: grants fetch or data access one at a time (round-robin on tie),
//          runs the memory strobe until MOC or timeout, and returns aligned,
//          extended read data with one-cycle done/err pulses.
// Ports:
//   clk    clock
//   Reset  synchronous active-high reset
//   bus    mem_port_arbiter_if.slave (request/response + memory signals)
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic               clk,
  input logic               Reset,
  mem_port_arbiter_if.slave bus
);
  import mem_port_arbiter_pkg::*;

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic              uns_q, uns_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dp_rdata_q, dp_rdata_d;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_data;
  logic              pick_fetch;

  // Works from registered access attributes so mem_wdata is stable for
  // the whole access and the load path sees the granted address.
  mem_port_arbiter_load_align u_align (
    .size_i    (size_q),
    .uns_i     (uns_q),
    .addr_lo_i (addr_q[1:0]),
    .rdata_i   (bus.mem_rdata),
    .wdata_i   (wdata_q),
    .ld_data_o (ld_data),
    .st_data_o (st_data)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= REQ_FETCH;
      last_grant_q <= REQ_DATA;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      rw_q         <= 1'b0;
      uns_q        <= 1'b0;
      size_q       <= SZ_BYTE;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      dp_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      rw_q         <= rw_d;
      uns_q        <= uns_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      dp_rdata_q   <= dp_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    rw_d         = rw_q;
    uns_d        = uns_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    dp_rdata_d   = dp_rdata_q;
    // Fetch wins when alone, or on a tie when data went last.
    pick_fetch   = bus.if_req && (!bus.dp_req || last_grant_q == REQ_DATA);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.if_req || bus.dp_req) begin
          cnt_d = '0;
          if (pick_fetch) begin
            grant_d = REQ_FETCH;
            addr_d  = bus.if_addr;
            size_d  = SZ_WORD;
            rw_d    = 1'b0;
            uns_d   = 1'b1;
            wdata_d = '0;
          end else begin
            grant_d = REQ_DATA;
            addr_d  = bus.dp_addr;
            size_d  = bus.dp_size;
            rw_d    = bus.dp_rw;
            uns_d   = bus.dp_unsigned;
            wdata_d = bus.dp_wdata;
          end
          // Illegal accesses never strobe memory; they report straight away.
          err_d   = access_illegal(size_d, addr_d[1:0]);
          state_d = err_d ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (bus.MOC) begin
          state_d = ST_DONE;
          err_d   = 1'b0;
          if (!rw_q) begin
            if (grant_q == REQ_FETCH) if_rdata_d = bus.mem_rdata;
            else                      dp_rdata_d = ld_data;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        last_grant_d = grant_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.memEnable = (state_q == ST_ACCESS);
    bus.RW        = rw_q;
    bus.mem_addr  = addr_q;
    bus.mem_size  = size_q;
    bus.mem_wdata = st_data;
    bus.if_done   = (state_q == ST_DONE) && (grant_q == REQ_FETCH) && !err_q;
    bus.if_err    = (state_q == ST_DONE) && (grant_q == REQ_FETCH) &&  err_q;
    bus.dp_done   = (state_q == ST_DONE) && (grant_q == REQ_DATA)  && !err_q;
    bus.dp_err    = (state_q == ST_DONE) && (grant_q == REQ_DATA)  &&  err_q;
    bus.if_rdata  = if_rdata_q;
    bus.dp_rdata  = dp_rdata_q;
  end

endmodule
